// File: rtl/enemy_datapath.sv
// Enemy datapath: position-update tick generator, spawn/descent position
// registers, and combinational bottom/collision flags from the registered position.
module enemy_datapath #(
  parameter int unsigned RATE_DIV = 833333,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned X_MAX    = 156,
  parameter int unsigned ENEMY_W  = 4,
  parameter int unsigned ENEMY_H  = 4,
  parameter int unsigned PLAYER_W = 4,
  parameter int unsigned PLAYER_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inResetState,
  input  logic       inUpdatePositionStateE,
  input  logic [7:0] spawnX,
  input  logic [7:0] bulletX,
  input  logic [6:0] bulletY,
  input  logic       bulletValid,
  input  logic [7:0] playerX,
  input  logic [6:0] playerY,
  output logic       updatePosition,
  output logic       bottomReached,
  output logic       collidedWithBullet,
  output logic       collidedWithPlayer,
  output logic [7:0] enemyX,
  output logic [6:0] enemyY,
  output logic       active
);

  localparam int unsigned CNT_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int unsigned Y_LIMIT  = SCREEN_H - ENEMY_H;
  localparam int unsigned BULLET_W = 1;
  localparam int unsigned BULLET_H = 2;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_last_c;
  logic             upd_q;
  logic             upd_rise_c;
  logic             y_sat_c;
  logic [6:0]       y_next_c;
  logic [7:0]       spawn_x_c;

  assign tick_last_c = (tick_cnt == CNT_W'(RATE_DIV - 1));

  // Free-running tick divider, parked at zero while the controller waits to spawn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt       <= '0;
      updatePosition <= 1'b0;
    end else if (inResetState) begin
      tick_cnt       <= '0;
      updatePosition <= 1'b0;
    end else begin
      updatePosition <= tick_last_c;
      tick_cnt       <= tick_last_c ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  assign upd_rise_c = inUpdatePositionStateE & ~upd_q;

  // Saturation test done one bit wider so enemyY+STEP can never wrap
  assign y_sat_c   = (({1'b0, enemyY} + 8'(STEP)) >= 8'(Y_LIMIT));
  assign y_next_c  = y_sat_c ? 7'(Y_LIMIT) : (enemyY + 7'(STEP));
  assign spawn_x_c = (spawnX > 8'(X_MAX)) ? 8'(X_MAX) : spawnX;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q  <= 1'b0;
      enemyX <= '0;
      enemyY <= '0;
      active <= 1'b0;
    end else begin
      upd_q <= inUpdatePositionStateE;
      if (inResetState) begin
        enemyX <= spawn_x_c;
        enemyY <= '0;
        active <= 1'b0;
      end else if (upd_rise_c) begin
        enemyY <= y_next_c;
        active <= 1'b1;
      end
    end
  end

  // Strict box overlap: boxes that only share an edge do not collide
  function automatic logic overlap(
    input logic [8:0] ax, input logic [8:0] ay, input logic [8:0] aw, input logic [8:0] ah,
    input logic [8:0] bx, input logic [8:0] by, input logic [8:0] bw, input logic [8:0] bh
  );
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  assign bottomReached = active && (enemyY >= 7'(Y_LIMIT));

  assign collidedWithBullet = active && bulletValid &&
    overlap(9'(enemyX), 9'(enemyY), 9'(ENEMY_W), 9'(ENEMY_H),
            9'(bulletX), 9'(bulletY), 9'(BULLET_W), 9'(BULLET_H));

  assign collidedWithPlayer = active &&
    overlap(9'(enemyX), 9'(enemyY), 9'(ENEMY_W), 9'(ENEMY_H),
            9'(playerX), 9'(playerY), 9'(PLAYER_W), 9'(PLAYER_H));

endmodule

// File: tb/tb_enemy_datapath.sv
// Directed bench for enemy_datapath with a short tick period (RATE_DIV=4).
module tb_enemy_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       inResetState;
  logic       inUpdatePositionStateE;
  logic [7:0] spawnX;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       bulletValid;
  logic [7:0] playerX;
  logic [6:0] playerY;
  logic       updatePosition;
  logic       bottomReached;
  logic       collidedWithBullet;
  logic       collidedWithPlayer;
  logic [7:0] enemyX;
  logic [6:0] enemyY;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  enemy_datapath #(.RATE_DIV(4), .STEP(1)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .inResetState           (inResetState),
    .inUpdatePositionStateE (inUpdatePositionStateE),
    .spawnX                 (spawnX),
    .bulletX                (bulletX),
    .bulletY                (bulletY),
    .bulletValid            (bulletValid),
    .playerX                (playerX),
    .playerY                (playerY),
    .updatePosition         (updatePosition),
    .bottomReached          (bottomReached),
    .collidedWithBullet     (collidedWithBullet),
    .collidedWithPlayer     (collidedWithPlayer),
    .enemyX                 (enemyX),
    .enemyY                 (enemyY),
    .active                 (active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_upd();
    @(negedge clk) inUpdatePositionStateE = 1'b1;
    @(negedge clk) inUpdatePositionStateE = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse_upd();
  endtask

  initial begin
    reset = 1'b1;
    inResetState = 1'b0;
    inUpdatePositionStateE = 1'b0;
    spawnX = 8'd0;
    bulletX = 8'd0; bulletY = 7'd0; bulletValid = 1'b1;
    playerX = 8'd0; playerY = 7'd0;

    // Reset state; bullet/player sit on the enemy, but active=0 gates the flags
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_upd",    32'(updatePosition), 32'd0);
    check_eq("rst_x",      32'(enemyX), 32'd0);
    check_eq("rst_y",      32'(enemyY), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_bottom", 32'(bottomReached), 32'd0);
    check_eq("rst_cbul",   32'(collidedWithBullet), 32'd0);
    check_eq("rst_cply",   32'(collidedWithPlayer), 32'd0);

    // Tick timing: pulse after edges 4, 8, 12 (cycles 5, 9, 13)
    @(negedge clk) reset = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("tick_e%0d", n), 32'(updatePosition), (n % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Spawn state: no ticks, clamp of spawn column
    @(negedge clk) begin inResetState = 1'b1; spawnX = 8'd200; end
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("notick_e%0d", n), 32'(updatePosition), 32'd0);
    end
    check_eq("clamp_x",      32'(enemyX), 32'd156);
    check_eq("clamp_y",      32'(enemyY), 32'd0);
    check_eq("clamp_active", 32'(active), 32'd0);
    @(negedge clk) spawnX = 8'd40;
    @(negedge clk);
    check_eq("spawn_x", 32'(enemyX), 32'd40);

    // Descend to 10, then hold enable for 5 cycles: one step only
    @(negedge clk) inResetState = 1'b0;
    pulses(10);
    check_eq("desc_y10", 32'(enemyY), 32'd10);
    check_eq("desc_act", 32'(active), 32'd1);
    @(negedge clk) inUpdatePositionStateE = 1'b1;
    repeat (5) @(negedge clk);
    inUpdatePositionStateE = 1'b0;
    check_eq("held_y11", 32'(enemyY), 32'd11);

    // Collisions at enemy (40,20)
    pulses(9);
    check_eq("coll_y20", 32'(enemyY), 32'd20);
    bulletX = 8'd41; bulletY = 7'd22; bulletValid = 1'b1;
    playerX = 8'd43; playerY = 7'd23;
    #1;
    check_eq("cbul_hit",   32'(collidedWithBullet), 32'd1);
    check_eq("cply_hit",   32'(collidedWithPlayer), 32'd1);
    bulletValid = 1'b0; #1;
    check_eq("cbul_inval", 32'(collidedWithBullet), 32'd0);
    bulletX = 8'd44; bulletY = 7'd20; bulletValid = 1'b1;
    playerX = 8'd36; playerY = 7'd20;
    #1;
    check_eq("cbul_edge",  32'(collidedWithBullet), 32'd0);
    check_eq("cply_edge",  32'(collidedWithPlayer), 32'd0);
    bulletX = 8'd43; bulletY = 7'd18; #1;
    check_eq("cbul_top",   32'(collidedWithBullet), 32'd0);
    bulletY = 7'd19; #1;
    check_eq("cbul_top1",  32'(collidedWithBullet), 32'd1);
    bulletValid = 1'b0;
    check_eq("enemyx_fix", 32'(enemyX), 32'd40);

    // Saturation at 116
    pulses(95);
    check_eq("sat_y115",    32'(enemyY), 32'd115);
    check_eq("sat_bot115",  32'(bottomReached), 32'd0);
    pulses(2);
    check_eq("sat_y116",    32'(enemyY), 32'd116);
    check_eq("sat_bot116",  32'(bottomReached), 32'd1);
    pulse_upd();
    check_eq("sat_y_hold",  32'(enemyY), 32'd116);
    check_eq("sat_bot_hold",32'(bottomReached), 32'd1);

    // Spawn state wins over a simultaneous update
    @(negedge clk) begin inResetState = 1'b1; inUpdatePositionStateE = 1'b1; end
    @(negedge clk);
    check_eq("prio_y",      32'(enemyY), 32'd0);
    check_eq("prio_active", 32'(active), 32'd0);
    inUpdatePositionStateE = 1'b0;

    // Async reset between edges at enemyY=50
    @(negedge clk) inResetState = 1'b0;
    pulses(50);
    check_eq("pre_arst_y", 32'(enemyY), 32'd50);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_y",      32'(enemyY), 32'd0);
    check_eq("arst_active", 32'(active), 32'd0);
    check_eq("arst_x",      32'(enemyX), 32'd0);
    check_eq("arst_bottom", 32'(bottomReached), 32'd0);

    // First tick after release lands RATE_DIV+1 cycles later
    @(negedge clk) reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("retick_e%0d", n), 32'(updatePosition), (n == 4) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
